// File: rtl/bus_seq_pkg.sv
// Shared state encoding and pin constants for the external bus cycle sequencer.
package bus_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR_LO = 2'd1,
    ST_ADDR_HI = 2'd2,
    ST_DATA    = 2'd3
  } bus_state_e;

  localparam logic [7:0] OE_DRIVE = 8'hFF;
  localparam logic [7:0] OE_FLOAT = 8'h00;
  localparam logic       RW_READ  = 1'b0;
  localparam logic       RW_WRITE = 1'b1;

  function automatic logic [7:0] drive_mask(input logic rw);
    return (rw == RW_WRITE) ? OE_DRIVE : OE_FLOAT;
  endfunction

endpackage

// File: rtl/bus_cycle_sequencer_wait_counter.sv
// Loadable 2-bit down-counter that stretches the data phase by DATA_WAIT cycles.
module bus_wait_counter (
  input  logic       clk,
  input  logic       res,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [1:0] count_r;

  // Load wins over decrement; decrement stops at zero.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      count_r <= 2'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != 2'd0)) begin
      count_r <= count_r - 2'd1;
    end
  end

  assign zero = (count_r == 2'd0);

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Sequences one core access as ADDR_LO, ADDR_HI and DATA pin phases, then acks.
// Optional BUS_RDY_WAIT_EN adds a bus_rdy input that extends the final data cycle.
module bus_cycle_sequencer
  import bus_seq_pkg::*;
#(
  parameter int DATA_WAIT = 0,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              req,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              ack,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic [1:0]        bus_phase,
  output logic [7:0]        bus_addr_out,
  output logic [7:0]        bus_data_out,
  input  logic [7:0]        bus_data_in,
  output logic [7:0]        bus_data_oe
`ifdef BUS_RDY_WAIT_EN
  ,
  input  logic              bus_rdy
`endif
);

  if ((DATA_WAIT < 0) || (DATA_WAIT > 3)) begin : g_bad_wait
    $error("bus_cycle_sequencer: DATA_WAIT must be in 0..3");
  end
  if (ADDR_W != 16) begin : g_bad_addr_w
    $error("bus_cycle_sequencer: ADDR_W must be 16");
  end

  localparam logic [1:0] WAIT_INIT = 2'(DATA_WAIT);

  bus_state_e  state_r;
  bus_state_e  state_next_s;
  logic [15:0] addr_r;
  logic        rw_r;
  logic [7:0]  wdata_r;
  logic        accept_s;
  logic        rdy_s;
  logic        cnt_zero_s;
  logic        data_done_s;
  logic [7:0]  addr_next_s;
  logic [7:0]  dout_next_s;
  logic [7:0]  oe_next_s;
  logic        ack_next_s;
  logic [7:0]  rdata_next_s;

`ifdef BUS_RDY_WAIT_EN
  assign rdy_s = bus_rdy;
`else
  assign rdy_s = 1'b1;
`endif

  // Held req must not restart an access during the ack cycle.
  assign accept_s    = (state_r == ST_IDLE) && req && !ack;
  assign data_done_s = (state_r == ST_DATA) && cnt_zero_s && rdy_s;

  bus_wait_counter u_wait (
    .clk      (clk),
    .res      (res),
    .load     (state_r == ST_ADDR_HI),
    .load_val (WAIT_INIT),
    .dec      (state_r == ST_DATA),
    .zero     (cnt_zero_s)
  );

  // Next state and the pin values that the output registers take at the same edge.
  always_comb begin
    state_next_s = state_r;
    addr_next_s  = 8'h00;
    dout_next_s  = 8'h00;
    oe_next_s    = OE_FLOAT;
    ack_next_s   = 1'b0;
    rdata_next_s = rdata;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_ADDR_LO;
          addr_next_s  = req_addr[7:0];
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ADDR_LO: begin
        state_next_s = ST_ADDR_HI;
        addr_next_s  = addr_r[15:8];
      end
      ST_ADDR_HI: begin
        state_next_s = ST_DATA;
        addr_next_s  = addr_r[15:8];
        dout_next_s  = wdata_r & drive_mask(rw_r);
        oe_next_s    = drive_mask(rw_r);
      end
      ST_DATA: begin
        if (data_done_s) begin
          state_next_s = ST_IDLE;
          ack_next_s   = 1'b1;
          if (rw_r == RW_READ) begin
            rdata_next_s = bus_data_in;
          end else begin
            rdata_next_s = rdata;
          end
        end else begin
          state_next_s = ST_DATA;
          addr_next_s  = addr_r[15:8];
          dout_next_s  = wdata_r & drive_mask(rw_r);
          oe_next_s    = drive_mask(rw_r);
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Request capture; address, direction and write data are only sampled on accept.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      addr_r  <= 16'h0000;
      rw_r    <= RW_READ;
      wdata_r <= 8'h00;
    end else if (accept_s) begin
      addr_r  <= req_addr[15:0];
      rw_r    <= req_rw;
      wdata_r <= req_wdata;
    end
  end

  // State and pin registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r      <= ST_IDLE;
      bus_phase    <= 2'd0;
      busy         <= 1'b0;
      bus_addr_out <= 8'h00;
      bus_data_out <= 8'h00;
      bus_data_oe  <= OE_FLOAT;
      ack          <= 1'b0;
      rdata        <= 8'h00;
    end else begin
      state_r      <= state_next_s;
      bus_phase    <= state_next_s;
      busy         <= (state_next_s != ST_IDLE);
      bus_addr_out <= addr_next_s;
      bus_data_out <= dout_next_s;
      bus_data_oe  <= oe_next_s;
      ack          <= ack_next_s;
      rdata        <= rdata_next_s;
    end
  end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Bench: two sequencers (DATA_WAIT 0 and 2) against a transaction-position model.
module tb_bus_cycle_sequencer;

  localparam int W0 = 0;
  localparam int W1 = 2;

  logic        clk = 1'b0;
  logic        res;
  logic [1:0]  req;
  logic        req_rw;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  bus_data_in;
  logic [1:0]  ack;
  logic [1:0]  busy;
  logic [7:0]  rdata  [2];
  logic [1:0]  phase  [2];
  logic [7:0]  addr_o [2];
  logic [7:0]  dout   [2];
  logic [7:0]  oe     [2];
  logic        rdy_eff;
`ifdef BUS_RDY_WAIT_EN
  logic        bus_rdy;
  assign rdy_eff = bus_rdy;
`else
  assign rdy_eff = 1'b1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  bus_cycle_sequencer #(.DATA_WAIT(W0)) dut0 (
    .clk(clk), .res(res), .req(req[0]), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0]),
    .bus_phase(phase[0]), .bus_addr_out(addr_o[0]), .bus_data_out(dout[0]),
    .bus_data_in(bus_data_in), .bus_data_oe(oe[0])
`ifdef BUS_RDY_WAIT_EN
    , .bus_rdy(bus_rdy)
`endif
  );

  bus_cycle_sequencer #(.DATA_WAIT(W1)) dut1 (
    .clk(clk), .res(res), .req(req[1]), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1]),
    .bus_phase(phase[1]), .bus_addr_out(addr_o[1]), .bus_data_out(dout[1]),
    .bus_data_in(bus_data_in), .bus_data_oe(oe[1])
`ifdef BUS_RDY_WAIT_EN
    , .bus_rdy(bus_rdy)
`endif
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, idx, $time, act, exp);
    end
  endtask

  // Model: an access is a count of cycles since accept; position 1 is the low
  // address byte, 2 the high byte, 3..3+wait the data phase, which may be
  // extended by bus_rdy on its last cycle.
  bit          m_act  [2];
  int          m_pos  [2];
  logic [15:0] m_addr [2];
  logic        m_rw   [2];
  logic [7:0]  m_wd   [2];
  logic [7:0]  m_rd   [2];
  logic        m_ack  [2];

  function automatic int wait_of(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  always @(posedge clk or posedge res) begin
    for (int i = 0; i < 2; i++) begin
      if (res) begin
        m_act[i] <= 1'b0;
        m_pos[i] <= 0;
        m_ack[i] <= 1'b0;
        m_rd[i]  <= 8'h00;
      end else if (!m_act[i]) begin
        m_ack[i] <= 1'b0;
        if (req[i] && !m_ack[i]) begin
          m_act[i]  <= 1'b1;
          m_pos[i]  <= 1;
          m_addr[i] <= req_addr;
          m_rw[i]   <= req_rw;
          m_wd[i]   <= req_wdata;
        end
      end else if (m_pos[i] < 3 + wait_of(i)) begin
        m_pos[i] <= m_pos[i] + 1;
      end else if (rdy_eff) begin
        m_act[i] <= 1'b0;
        m_pos[i] <= 0;
        m_ack[i] <= 1'b1;
        if (!m_rw[i]) m_rd[i] <= bus_data_in;
      end
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("phase", i, 32'(phase[i]),
            m_act[i] ? ((m_pos[i] >= 3) ? 32'd3 : 32'(m_pos[i])) : 32'd0);
        chk("busy", i, 32'(busy[i]), 32'(m_act[i]));
        chk("addr", i, 32'(addr_o[i]),
            !m_act[i] ? 32'd0 : (m_pos[i] == 1) ? 32'(m_addr[i][7:0]) : 32'(m_addr[i][15:8]));
        chk("dout", i, 32'(dout[i]),
            (m_act[i] && m_pos[i] >= 3 && m_rw[i]) ? 32'(m_wd[i]) : 32'd0);
        chk("oe", i, 32'(oe[i]),
            (m_act[i] && m_pos[i] >= 3 && m_rw[i]) ? 32'hFF : 32'd0);
        chk("ack", i, 32'(ack[i]), 32'(m_ack[i]));
        chk("rdata", i, 32'(rdata[i]), 32'(m_rd[i]));
      end
    end
  end

  initial begin
    int t0a, t0b, t1a, t1b, t;
    bit found;
    req = 2'b00; req_rw = 1'b0; req_addr = 16'h0000; req_wdata = 8'h00; bus_data_in = 8'h00;
`ifdef BUS_RDY_WAIT_EN
    bus_rdy = 1'b1;
`endif
    res = 1'b0;
    #1 res = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_phase", i, 32'(phase[i]), 32'd0);
      chk("rst_addr", i, 32'(addr_o[i]), 32'd0);
      chk("rst_ack", i, 32'(ack[i]), 32'd0);
      chk("rst_oe", i, 32'(oe[i]), 32'd0);
    end
    @(negedge clk);
    res = 1'b0;
    repeat (2) @(negedge clk);

    // Read 0x12AB with bus data 0x5A.
    req = 2'b11; req_rw = 1'b0; req_addr = 16'h12AB; bus_data_in = 8'h5A;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_addr = 16'h0000;
      if (c == 1) begin chk("rd_lo", 0, 32'(addr_o[0]), 32'hAB); chk("rd_ph1", 0, 32'(phase[0]), 32'd1); end
      if (c == 2) chk("rd_hi", 0, 32'(addr_o[0]), 32'h12);
      if (c == 3) begin chk("rd_data_addr", 0, 32'(addr_o[0]), 32'h12); chk("rd_oe", 0, 32'(oe[0]), 32'h00); end
      if (c == 3) chk("rd_noack", 0, 32'(ack[0]), 32'd0);
      if (c == 4) begin chk("rd_ack", 0, 32'(ack[0]), 32'd1); chk("rd_rdata", 0, 32'(rdata[0]), 32'h5A); req[0] = 1'b0; end
      if (c == 6) begin chk("rd_ack", 1, 32'(ack[1]), 32'd1); req[1] = 1'b0; end
    end
    repeat (2) @(negedge clk);

    // Write 0xFFFC / 0x3C; later input changes must not leak in.
    req = 2'b11; req_rw = 1'b1; req_addr = 16'hFFFC; req_wdata = 8'h3C;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_addr = 16'h0000; req_wdata = 8'h00; req_rw = 1'b0;
      if (c == 1) chk("wr_lo", 1, 32'(addr_o[1]), 32'hFC);
      if (c == 2) chk("wr_hi", 1, 32'(addr_o[1]), 32'hFF);
      if (c >= 3 && c <= 5) begin chk("wr_dout", 1, 32'(dout[1]), 32'h3C); chk("wr_oe", 1, 32'(oe[1]), 32'hFF); end
      if (c == 4) begin chk("wr_ack", 0, 32'(ack[0]), 32'd1); req[0] = 1'b0; end
      if (c == 6) begin chk("wr_ack", 1, 32'(ack[1]), 32'd1); chk("wr_oe_ack", 1, 32'(oe[1]), 32'h00); req[1] = 1'b0; end
    end
    repeat (2) @(negedge clk);

    // Held req: reads of 0x0000 then 0x0001, spacing 5+wait.
    t0a = -1; t0b = -1; t1a = -1; t1b = -1;
    req = 2'b11; req_rw = 1'b0; req_addr = 16'h0000;
    for (t = 0; t < 24; t++) begin
      @(negedge clk);
      if (phase[0] == 2'd1) begin
        if (t0a < 0) begin t0a = t; req_addr = 16'h0001; end
        else if (t0b < 0) begin t0b = t; chk("b2b_addr", 0, 32'(addr_o[0]), 32'h01); end
      end
      if (phase[1] == 2'd1) begin
        if (t1a < 0) t1a = t;
        else if (t1b < 0) t1b = t;
      end
    end
    chk("b2b_gap", 0, 32'(t0b - t0a), 32'd5);
    chk("b2b_gap", 1, 32'(t1b - t1a), 32'd7);
    req = 2'b00;
    repeat (10) @(negedge clk);

    // Reset while a write is driving the bus.
    req = 2'b11; req_rw = 1'b1; req_addr = 16'h4321; req_wdata = 8'hA5;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (oe[1] == 8'hFF) found = 1'b1;
    end
    chk("rst_wait_oe", 1, 32'(found), 32'd1);
    #2 res = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_oe", i, 32'(oe[i]), 32'd0);
      chk("arst_dout", i, 32'(dout[i]), 32'd0);
      chk("arst_addr", i, 32'(addr_o[i]), 32'd0);
      chk("arst_busy", i, 32'(busy[i]), 32'd0);
    end
    req = 2'b00;
    repeat (2) @(negedge clk);
    res = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("post_rst_ack", i, 32'(ack[i]), 32'd0);
      chk("post_rst_phase", i, 32'(phase[i]), 32'd0);
    end

    // req dropped in ADDR_LO; address 0x8001 must persist.
    req = 2'b11; req_rw = 1'b0; req_addr = 16'h8001;
    @(negedge clk);
    chk("drop_lo", 0, 32'(addr_o[0]), 32'h01);
    req = 2'b00; req_addr = 16'h1234;
    @(negedge clk);
    chk("drop_hi", 0, 32'(addr_o[0]), 32'h80);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (ack[0]) found = 1'b1;
    end
    chk("drop_ack", 0, 32'(found), 32'd1);
    repeat (6) @(negedge clk);

`ifdef BUS_RDY_WAIT_EN
    // bus_rdy low for three data cycles on a read of 0x0200.
    req = 2'b01; req_rw = 1'b0; req_addr = 16'h0200; bus_rdy = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 3) bus_data_in = 8'h11;
      if (c == 4) begin bus_data_in = 8'h22; chk("rdy_stall", 0, 32'(phase[0]), 32'd3); end
      if (c == 5) begin bus_data_in = 8'h33; chk("rdy_stall", 0, 32'(phase[0]), 32'd3); end
      if (c == 6) begin bus_data_in = 8'h77; bus_rdy = 1'b1; chk("rdy_noack", 0, 32'(ack[0]), 32'd0); end
      if (c == 7) begin chk("rdy_ack", 0, 32'(ack[0]), 32'd1); chk("rdy_rdata", 0, 32'(rdata[0]), 32'h77); req = 2'b00; end
    end
    repeat (4) @(negedge clk);
`endif

    // Random traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req[0]      = ($urandom_range(0, 3) != 0);
      req[1]      = ($urandom_range(0, 3) != 0);
      req_rw      = 1'($urandom_range(0, 1));
      req_addr    = 16'($urandom);
      req_wdata   = 8'($urandom);
      bus_data_in = 8'($urandom);
`ifdef BUS_RDY_WAIT_EN
      bus_rdy     = ($urandom_range(0, 9) < 7);
`endif
    end
    req = 2'b00;
`ifdef BUS_RDY_WAIT_EN
    bus_rdy = 1'b1;
`endif
    repeat (12) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
